memory_cycle: RTL

- Consumer end of the EX/MEM pipeline interface in the 5-stage RV32I core.
- Takes the registered execute-stage outputs and performs the data-memory access over a req/ack handshake.
- Stalls upstream while an access is outstanding.
- Drives the MEM/WB pipeline register into the writeback stage.

---
 rtl/memory_cycle.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/memory_cycle.sv
// MEM stage of the RV32I pipeline: issues the data-memory access over req/ack,
// stalls upstream while it is outstanding and drives the MEM/WB register.
// Optional access timeout with a sticky error flag: define DMEM_TIMEOUT_EN.
module memory_cycle #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [4:0]  RdM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PcPlus4M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        StallM,
  output logic        RegWriteW,
  output logic [1:0]  ResultSrcW,
  output logic [4:0]  RdW,
  output logic [31:0] ALUResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PcPlus4W,
  output logic        MemErrW
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_access;
  logic        w_stall;
  logic        w_capture;
  logic        w_use_rdata;
  logic        w_abort;
  logic        w_timeout_hit;
  logic [1:0]  w_result_src;

  logic        r_regwrite;
  logic [1:0]  r_result_src;
  logic [4:0]  r_rd;
  logic [31:0] r_alu_result;
  logic [31:0] r_read_data;
  logic [31:0] r_pc_plus4;

  // A store takes precedence over a simultaneous load select.
  assign w_access     = MemWriteM | (ResultSrcM == 2'b01);
  assign w_result_src = (ResultSrcM == 2'b11) ? 2'b00 : ResultSrcM;

  // Request and stall are gated by reset so they drop the moment rst falls.
  assign dmem_req   = rst & w_access;
  assign dmem_we    = MemWriteM;
  assign dmem_addr  = ALUResultM;
  assign dmem_wdata = WriteDataM;
  assign StallM     = rst & w_stall;

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? 16 : 8;
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_mem_err;

  assign w_timeout_hit = (r_cnt == TERM_CNT);
  assign MemErrW       = r_mem_err;

  // Timeout counter and sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= {CNT_W{1'b0}};
      r_mem_err <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && (w_state_nxt == ST_BUSY)) begin
        r_cnt <= {CNT_W{1'b0}};
      end else if ((r_state == ST_BUSY) && w_stall) begin
        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_cnt <= r_cnt;
      end
      if (w_abort) begin
        r_mem_err <= 1'b1;
      end else begin
        r_mem_err <= r_mem_err;
      end
    end
  end
`else
  logic w_unused_timeout;

  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
  assign w_timeout_hit    = 1'b0;
  assign MemErrW          = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, stall and MEM/WB load decision.
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_capture   = 1'b0;
    w_use_rdata = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_access) begin
          if (dmem_ack) begin
            w_capture   = 1'b1;
            w_use_rdata = ~MemWriteM;
          end else begin
            w_stall     = 1'b1;
            w_state_nxt = ST_BUSY;
          end
        end else begin
          w_capture = 1'b1;
        end
      end
      ST_BUSY: begin
        if (!w_access) begin
          // Only reachable if upstream ignored the stall; recover cleanly.
          w_capture   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (dmem_ack) begin
          w_capture   = 1'b1;
          w_use_rdata = ~MemWriteM;
          w_state_nxt = ST_IDLE;
        end else if (w_timeout_hit) begin
          w_abort     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_stall = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // MEM/WB pipeline register; anything not captured becomes a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_regwrite   <= 1'b0;
      r_result_src <= 2'b00;
      r_rd         <= 5'd0;
      r_alu_result <= 32'd0;
      r_read_data  <= 32'd0;
      r_pc_plus4   <= 32'd0;
    end else if (w_capture) begin
      r_regwrite   <= RegWriteM;
      r_result_src <= w_result_src;
      r_rd         <= RdM;
      r_alu_result <= ALUResultM;
      r_read_data  <= w_use_rdata ? dmem_rdata : 32'd0;
      r_pc_plus4   <= PcPlus4M;
    end else begin
      r_regwrite   <= 1'b0;
      r_result_src <= 2'b00;
      r_rd         <= 5'd0;
      r_alu_result <= 32'd0;
      r_read_data  <= 32'd0;
      r_pc_plus4   <= 32'd0;
    end
  end

  assign RegWriteW  = r_regwrite;
  assign ResultSrcW = r_result_src;
  assign RdW        = r_rd;
  assign ALUResultW = r_alu_result;
  assign ReadDataW  = r_read_data;
  assign PcPlus4W   = r_pc_plus4;

endmodule
